// File: rtl/servo_pwm_pkg.sv
// Shared register map, AXI response codes, FSM encodings and helpers for servo_pwm_axil.
package servo_pwm_pkg;

  localparam logic [31:0] REG_CTRL       = 32'h00;
  localparam logic [31:0] REG_PERIOD     = 32'h04;
  localparam logic [31:0] REG_PRESCALE   = 32'h08;
  localparam logic [31:0] REG_STATUS     = 32'h0C;
  localparam logic [31:0] REG_PULSE_BASE = 32'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_ACC, WR_RESP} wr_st_e;
  typedef enum logic [1:0] {RD_IDLE, RD_ACC, RD_DATA} rd_st_e;

  // Saturate v into [lo, hi].
  function automatic logic [31:0] clamp(input logic [31:0] v, input logic [31:0] lo,
                                        input logic [31:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  // Byte-lane merge of write data onto the current register image.
  function automatic logic [31:0] wmerge(input logic [31:0] cur, input logic [31:0] wd,
                                         input logic [3:0] strb);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One PWM lane: shadow pulse width reloaded at period boundaries, plus the output comparator.
module servo_pwm_channel
  import servo_pwm_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int RST_PULSE = 1500
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             load,
  input  logic             gen,
  input  logic             en,
  input  logic [CNT_W-1:0] pulse,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm_o
);

  logic [CNT_W-1:0] shadow_q, shadow_d;

  // Shadow follows the live register only when the top says the period boundary allows it.
  always_comb shadow_d = load ? pulse : shadow_q;

  // Shadow register.
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) shadow_q <= CNT_W'(RST_PULSE);
    else          shadow_q <= shadow_d;

  assign pwm_o = gen & en & (cnt < shadow_q);

endmodule

// File: rtl/servo_pwm_axil.sv
// AXI4-Lite servo PWM controller: register file, shared prescaler/period counter, NUM_CH lanes.
// Optional build macro SERVO_PWM_CLAMP_EN clamps PULSE writes to [MIN_PULSE, MAX_PULSE].
module servo_pwm_axil
  import servo_pwm_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int ADDR_W       = 6,
  parameter int CNT_W        = 16,
  parameter int RST_PRESCALE = 99,
  parameter int RST_PERIOD   = 20000,
  parameter int RST_PULSE    = 1500,
  parameter int MIN_PULSE    = 1000,
  parameter int MAX_PULSE    = 2000
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              period_tick_o
);

  wr_st_e wr_st_q, wr_st_d;
  rd_st_e rd_st_q, rd_st_d;
  logic gen_q, gen_d, tick_q, tick_d, wrap, wr_hit, rd_hit, ch_load;
  logic [NUM_CH-1:0]            en_q, en_d;
  logic [CNT_W-1:0]             period_q, period_d, prescale_q, prescale_d;
  logic [CNT_W-1:0]             presc_q, presc_d, cnt_q, cnt_d, per_sh_q, per_sh_d, per_last;
  logic [NUM_CH-1:0][CNT_W-1:0] pulse_q, pulse_d;
  logic [1:0]                   bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]                  rdata_q, rdata_d, ctrl_img, rd_img, wr_m, waddr_w, raddr_w;

  assign waddr_w = 32'(S_AXI_AWADDR) & 32'hFFFF_FFFC;
  assign raddr_w = 32'(S_AXI_ARADDR) & 32'hFFFF_FFFC;

  // CTRL image as seen by software.
  always_comb begin
    ctrl_img             = '0;
    ctrl_img[31]         = gen_q;
    ctrl_img[NUM_CH-1:0] = en_q;
  end

  // Write channel FSM: one-cycle AW/W accept, then hold B until taken.
  always_comb begin
    wr_st_d       = wr_st_q;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    unique case (wr_st_q)
      WR_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) wr_st_d = WR_ACC;
      WR_ACC: begin
        S_AXI_AWREADY = 1'b1;
        S_AXI_WREADY  = 1'b1;
        wr_st_d       = WR_RESP;
      end
      WR_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) wr_st_d = WR_IDLE;
      end
      default: wr_st_d = WR_IDLE;
    endcase
  end

  // Read channel FSM: one-cycle AR accept, then hold R until taken.
  always_comb begin
    rd_st_d       = rd_st_q;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    unique case (rd_st_q)
      RD_IDLE: if (S_AXI_ARVALID) rd_st_d = RD_ACC;
      RD_ACC: begin
        S_AXI_ARREADY = 1'b1;
        rd_st_d       = RD_DATA;
      end
      RD_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) rd_st_d = RD_IDLE;
      end
      default: rd_st_d = RD_IDLE;
    endcase
  end

  // Register writes land on the AW/W handshake edge; unknown or read-only targets get SLVERR.
  always_comb begin
    gen_d      = gen_q;
    en_d       = en_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    pulse_d    = pulse_q;
    bresp_d    = bresp_q;
    wr_m       = '0;
    wr_hit     = 1'b1;
    if (wr_st_q == WR_ACC) begin
      bresp_d = RESP_OKAY;
      if (waddr_w == REG_CTRL) begin
        wr_m  = wmerge(ctrl_img, S_AXI_WDATA, S_AXI_WSTRB);
        gen_d = wr_m[31];
        en_d  = wr_m[NUM_CH-1:0];
      end else if (waddr_w == REG_PERIOD) begin
        wr_m     = wmerge(32'(period_q), S_AXI_WDATA, S_AXI_WSTRB);
        period_d = wr_m[CNT_W-1:0];
      end else if (waddr_w == REG_PRESCALE) begin
        wr_m       = wmerge(32'(prescale_q), S_AXI_WDATA, S_AXI_WSTRB);
        prescale_d = wr_m[CNT_W-1:0];
      end else begin
        wr_hit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
          if (waddr_w == REG_PULSE_BASE + 32'(4*i)) begin
            wr_hit = 1'b1;
            wr_m   = wmerge(32'(pulse_q[i]), S_AXI_WDATA, S_AXI_WSTRB);
`ifdef SERVO_PWM_CLAMP_EN
            pulse_d[i] = CNT_W'(clamp(wr_m, 32'(MIN_PULSE), 32'(MAX_PULSE)));
`else
            pulse_d[i] = wr_m[CNT_W-1:0];
`endif
          end
        end
        if (!wr_hit) bresp_d = RESP_SLVERR;
      end
    end
  end

  // Read mux, captured on the AR handshake edge; unmapped reads return 0 with SLVERR.
  always_comb begin
    rd_img = '0;
    rd_hit = 1'b1;
    if      (raddr_w == REG_CTRL)     rd_img = ctrl_img;
    else if (raddr_w == REG_PERIOD)   rd_img = 32'(period_q);
    else if (raddr_w == REG_PRESCALE) rd_img = 32'(prescale_q);
    else if (raddr_w == REG_STATUS)   rd_img = 32'(cnt_q);
    else begin
      rd_hit = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (raddr_w == REG_PULSE_BASE + 32'(4*i)) begin
          rd_hit = 1'b1;
          rd_img = 32'(pulse_q[i]);
        end
      end
    end
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (rd_st_q == RD_ACC) begin
      rdata_d = rd_img;
      rresp_d = rd_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Prescaler and period counter; both parked at 0 while GEN is off.
  always_comb begin
    per_last = (per_sh_q == '0) ? '0 : per_sh_q - 1'b1;
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    wrap     = 1'b0;
    if (!gen_q) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (presc_q >= prescale_q) begin
      presc_d = '0;
      if (cnt_q >= per_last) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      presc_d = presc_q + 1'b1;
    end
    ch_load  = !gen_q || wrap;
    per_sh_d = ch_load ? period_q : per_sh_q;
    tick_d   = wrap;
  end

  // All state flops.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_st_q    <= WR_IDLE;
      rd_st_q    <= RD_IDLE;
      gen_q      <= 1'b0;
      en_q       <= '0;
      period_q   <= CNT_W'(RST_PERIOD);
      prescale_q <= CNT_W'(RST_PRESCALE);
      for (int i = 0; i < NUM_CH; i++) pulse_q[i] <= CNT_W'(RST_PULSE);
      bresp_q    <= '0;
      rresp_q    <= '0;
      rdata_q    <= '0;
      presc_q    <= '0;
      cnt_q      <= '0;
      per_sh_q   <= CNT_W'(RST_PERIOD);
      tick_q     <= 1'b0;
    end else begin
      wr_st_q    <= wr_st_d;
      rd_st_q    <= rd_st_d;
      gen_q      <= gen_d;
      en_q       <= en_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      pulse_q    <= pulse_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      per_sh_q   <= per_sh_d;
      tick_q     <= tick_d;
    end
  end

  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign period_tick_o = tick_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_pwm_channel #(.CNT_W(CNT_W), .RST_PULSE(RST_PULSE)) u_ch (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .load    (ch_load),
      .gen     (gen_q),
      .en      (en_q[i]),
      .pulse   (pulse_q[i]),
      .cnt     (cnt_q),
      .pwm_o   (pwm_o[i])
    );
  end

endmodule

// File: tb/tb_servo_pwm_axil.sv
// Randomized self-checking bench for servo_pwm_axil against a register/waveform reference model.
module tb_servo_pwm_axil;

  logic        ACLK = 1'b0, ARESETN = 1'b0;
  logic [6:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, period_tick_o;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [3:0]  pwm_o;

  servo_pwm_axil #(.NUM_CH(4), .ADDR_W(7)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .pwm_o(pwm_o), .period_tick_o(period_tick_o)
  );

  always #5 ACLK = ~ACLK;

  int unsigned cyc = 0, hs_cyc = 0, hs0 = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_ctrl, m_period, m_presc;
  logic [31:0] m_pulse [4];
  int          p_old [4];
  int          chg_ch, chg_val, chg_k;

  task automatic mdl_reset;
    m_ctrl = 0; m_period = 20000; m_presc = 99;
    for (int i = 0; i < 4; i++) m_pulse[i] = 1500;
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] c, input logic [31:0] d,
                                         input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? d[b*8 +: 8] : c[b*8 +: 8];
    return r;
  endfunction

  task automatic mdl_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [1:0] resp);
    logic [31:0] w, v;
    w = a & ~32'h3;
    resp = 2'b00;
    if (w == 0)      m_ctrl   = bmerge(m_ctrl, d, s) & 32'h8000_000F;
    else if (w == 4) m_period = bmerge(m_period, d, s) & 32'hFFFF;
    else if (w == 8) m_presc  = bmerge(m_presc, d, s) & 32'hFFFF;
    else if (w >= 32'h10 && w <= 32'h1C) begin
      v = bmerge(m_pulse[(w-16)/4], d, s);
`ifdef SERVO_PWM_CLAMP_EN
      v = (v < 1000) ? 1000 : (v > 2000) ? 2000 : v;
`else
      v = v & 32'hFFFF;
`endif
      m_pulse[(w-16)/4] = v;
    end else resp = 2'b10;
  endtask

  // STATUS is only read while GEN is off, where the count sits at 0.
  task automatic mdl_rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    logic [31:0] w;
    w = a & ~32'h3;
    resp = 2'b00;
    if (w == 0)       d = m_ctrl;
    else if (w == 4)  d = m_period;
    else if (w == 8)  d = m_presc;
    else if (w == 12) d = 0;
    else if (w >= 32'h10 && w <= 32'h1C) d = m_pulse[(w-16)/4];
    else begin d = 0; resp = 2'b10; end
  endtask

  // ---------------- bus tasks (enter and leave on a falling edge) ----------------
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    awaddr = a[6:0]; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    n = 0;
    @(negedge ACLK);
    while (!(awready && wready) && n < 20) begin @(negedge ACLK); n++; end
    chk("aw_hs", {31'b0, awready && wready}, 1);
    @(posedge ACLK); #1;
    awvalid = 0; wvalid = 0; hs_cyc = cyc;
    @(negedge ACLK);
    n = 0;
    while (!bvalid && n < 20) begin @(negedge ACLK); n++; end
    chk("b_vld", {31'b0, bvalid}, 1);
    resp = bresp;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a[6:0]; arvalid = 1; rready = 1;
    n = 0;
    @(negedge ACLK);
    while (!arready && n < 20) begin @(negedge ACLK); n++; end
    chk("ar_hs", {31'b0, arready}, 1);
    @(posedge ACLK); #1;
    arvalid = 0;
    @(negedge ACLK);
    n = 0;
    while (!rvalid && n < 20) begin @(negedge ACLK); n++; end
    chk("r_vld", {31'b0, rvalid}, 1);
    d = rdata; resp = rresp;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [1:0] r, er;
    axi_write(a, d, 4'hF, r);
    mdl_wr(a, d, 4'hF, er);
    chk($sformatf("bresp@%0h", a), r, er);
  endtask

  task automatic rd_chk(input logic [31:0] a);
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    axi_read(a, d, r);
    mdl_rd(a, ed, er);
    chk($sformatf("rdata@%0h", a), d, ed);
    chk($sformatf("rresp@%0h", a), r, er);
  endtask

  // Waveform model: cycle k after the GEN-on edge sits at tick k/len; each period of pe ticks
  // uses the pulse value latched at its first edge.
  task automatic mon_pwm(input int ncyc);
    int k, len, pe, tk, cntv, pstart, pv;
    logic [3:0] ep;
    len = int'(m_presc) + 1;
    pe  = (m_period == 0) ? 1 : int'(m_period);
    for (int c = 0; c < ncyc; c++) begin
      k      = int'(cyc - hs0);
      tk     = k / len;
      cntv   = tk % pe;
      pstart = (tk / pe) * pe * len;
      for (int i = 0; i < 4; i++) begin
        pv    = (i == chg_ch && pstart > chg_k) ? chg_val : p_old[i];
        ep[i] = m_ctrl[i] && (cntv < pv);
      end
      chk($sformatf("pwm k=%0d", k), pwm_o, ep);
      chk($sformatf("tick k=%0d", k), period_tick_o, (k > 0 && k % (len*pe) == 0));
      @(negedge ACLK);
    end
  endtask

  task automatic snap;
    for (int i = 0; i < 4; i++) p_old[i] = int'(m_pulse[i]);
  endtask

  logic [31:0] atab [14] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18,
                             32'h1C, 32'h20, 32'h24, 32'h3C, 32'h40, 32'h60, 32'h7C};

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    logic [1:0]  r, er;
    int          n;

    mdl_reset();
    #12;
    chk("rst_awready", {31'b0, awready}, 0);
    chk("rst_wready", {31'b0, wready}, 0);
    chk("rst_bvalid", {31'b0, bvalid}, 0);
    chk("rst_arready", {31'b0, arready}, 0);
    chk("rst_rvalid", {31'b0, rvalid}, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_pwm", pwm_o, 0);
    chk("rst_tick", period_tick_o, 0);
    @(negedge ACLK);
    ARESETN = 1;

    for (int i = 0; i < 8; i++) rd_chk(atab[i]);

    // Random register traffic, GEN kept off.
    for (int it = 0; it < 40; it++) begin
      a = atab[$urandom_range(0, 13)] | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        if ((a & ~32'h3) == 0) d[31] = 1'b0;
        s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, r);
        mdl_wr(a, d, s, er);
        chk($sformatf("rnd_bresp@%0h", a), r, er);
      end
      rd_chk(a);
    end

    // Error paths leave registers untouched.
    rd_chk(32'h40);
    wr(32'h0C, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) rd_chk(atab[i]);

    // Clamp / raw storage.
    wr(32'h14, 5000);
`ifdef SERVO_PWM_CLAMP_EN
    chk("clamp_model", m_pulse[1], 2000);
`else
    chk("raw_model", m_pulse[1], 5000);
`endif
    rd_chk(32'h14);

    // Scenario 1: 10-cycle period, mid-period pulse update on channel 0.
    wr(32'h00, 0); wr(32'h08, 0); wr(32'h04, 10); wr(32'h10, 3);
    wr(32'h14, $urandom_range(0, 12)); wr(32'h18, $urandom_range(0, 12));
    wr(32'h1C, $urandom_range(0, 12));
    snap();
    chg_ch = 0; chg_val = 0; chg_k = 1 << 30;
    wr(32'h00, 32'h8000_000B);
    hs0 = hs_cyc;
    fork
      mon_pwm(45);
      begin
        repeat (2) @(negedge ACLK);
        wr(32'h10, 6);
        chg_val = int'(m_pulse[0]);
        chg_k   = int'(hs_cyc - hs0);
      end
    join
    wr(32'h00, 0);
    chk("gen_off_pwm", pwm_o, 0);

    // Scenario 2: random prescale/period (including PERIOD=0), enables and pulses.
    chg_ch = -1;
    for (int rr = 0; rr < 3; rr++) begin
      wr(32'h08, $urandom_range(0, 3));
      wr(32'h04, $urandom_range(0, 6));
      for (int i = 0; i < 4; i++) wr(32'h10 + 32'(4*i), $urandom_range(0, 7));
      snap();
      wr(32'h00, 32'h8000_0000 | 32'($urandom_range(0, 15)));
      hs0 = hs_cyc;
      mon_pwm(50);
      wr(32'h00, 0);
      chk("gen_off2_pwm", pwm_o, 0);
    end

    // Asynchronous reset with a write response pending.
    wr(32'h08, 0); wr(32'h04, 10); wr(32'h10, 20); wr(32'h00, 32'h8000_0001);
    repeat (3) @(negedge ACLK);
    bready = 0;
    awaddr = 7'h04; wdata = 5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    n = 0;
    @(negedge ACLK);
    while (!awready && n < 20) begin @(negedge ACLK); n++; end
    @(posedge ACLK); #1;
    awvalid = 0; wvalid = 0;
    @(negedge ACLK);
    chk("pre_rst_bvalid", {31'b0, bvalid}, 1);
    chk("pre_rst_pwm", pwm_o, 4'b0001);
    #2 ARESETN = 0;
    #1;
    chk("arst_pwm", pwm_o, 0);
    chk("arst_bvalid", {31'b0, bvalid}, 0);
    chk("arst_tick", period_tick_o, 0);
    @(negedge ACLK);
    ARESETN = 1;
    mdl_reset();
    for (int i = 0; i < 8; i++) rd_chk(atab[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
